rx_asm: RTL

- UART receiver for the frame format produced by the team's transmitter; sits directly downstream of it on the serial line.
- Deserialises the line back into a DATA_WIDTH-bit word and checks even parity, either per byte or once per frame.
- Checks the stop bit and presents the word on a valid/ready output with a one-word holding register.
- Frame format: idle high; start bit 0; DATA_WIDTH data bits, LSB first; parity bit(s); stop bit 1. Parity bit = XOR of the covered data bits.

---
 rtl/rx_asm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rx_asm.sv
// UART receiver: synchronises rx_in, deserialises LSB-first data with even parity
// (per byte or per frame), checks the stop bit and holds one word for a valid/ready consumer.
module rx_asm #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  parity_per_byte,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [2:0]            state_o
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CWR  = $clog2(DATA_WIDTH + 1);
  localparam int CW   = (CWR > 3) ? CWR : 3;
  localparam logic [BW-1:0] BIT_LD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LD = (HALF > 0) ? BW'(HALF - 1) : '0;
  localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   sync_ext;
  logic                   rx_s;
  logic [2:0]             state_q, state_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
  logic                   ppb_q, ppb_d;
  logic                   tick, done, stop_bad;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   load;

  assign sync_ext = {sync_q, rx_in};
  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick     = (bcnt_q == '0);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ppb_d    = ppb_q;
    done     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          ppb_d    = parity_per_byte;
          shift_d  = '0;
          par_d    = 1'b0;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          // With no half-bit wait, this low sample already confirms the start bit.
          if (HALF == 0) begin
            state_d = S_DATA;
            bcnt_d  = BIT_LD;
          end else begin
            state_d = S_START;
            bcnt_d  = HALF_LD;
          end
        end
      end
      S_START: begin
        if (tick) begin
          state_d = rx_s ? S_IDLE : S_DATA;
          bcnt_d  = BIT_LD;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d  = {rx_s, shift_q[DATA_WIDTH-1:1]};
          par_d    = par_q ^ rx_s;
          bitcnt_d = bitcnt_q + CW'(1);
          bcnt_d   = BIT_LD;
          if ((ppb_q && bitcnt_d[2:0] == 3'd0) || bitcnt_d == LAST) state_d = S_PARITY;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (rx_s != par_q) perr_d = 1'b1;
          par_d   = 1'b0;
          bcnt_d  = BIT_LD;
          state_d = (ppb_q && bitcnt_q != LAST) ? S_DATA : S_STOP;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          done     = 1'b1;
          stop_bad = ~rx_s;
          state_d  = rx_s ? S_IDLE : S_BREAK;
          bcnt_d   = BIT_LD;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_BREAK: begin
        // A line held low must go high again before another start is accepted.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output handshake: data_out and flags are valid and stable while data_valid=1; the
  // word is consumed on data_valid & data_ready, and a frame completing in that same
  // cycle replaces it without a gap. A frame completing while full is dropped (overrun).
  always_comb begin
    load       = done & (~valid_q | data_ready);
    valid_d    = load | (valid_q & ~data_ready);
    ovr_d      = done & ~load;
    dout_d     = load ? shift_q  : dout_q;
    perr_out_d = load ? perr_q   : perr_out_q;
    ferr_d     = load ? stop_bad : ferr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ppb_q      <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_ext[SYNC_STAGES-1:0];
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ppb_q      <= ppb_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign state_o    = state_q;
endmodule
